// File: rtl/hex_display_if.sv
// hex_display_if: CPU register bus for the seven-segment display driver
interface hex_display_if;
    logic        en;
    logic        wr;
    logic        addr;
    logic [31:0] din;
    logic [31:0] dout;
    modport master (output en, wr, addr, din, input dout);
    modport slave  (input en, wr, addr, din, output dout);
endinterface

// File: rtl/hex_display.sv
// hex_display: bus-writable eight-digit seven-segment driver with blank/blink masks
module hex_display #(
    parameter logic [31:0] BLINK_DIV = 32'd25000000
) (
    input  logic         clk,
    input  logic         rst,
    hex_display_if.slave bus,
    output logic [6:0]   o_hex0_n,
    output logic [6:0]   o_hex1_n,
    output logic [6:0]   o_hex2_n,
    output logic [6:0]   o_hex3_n,
    output logic [6:0]   o_hex4_n,
    output logic [6:0]   o_hex5_n,
    output logic [6:0]   o_hex6_n,
    output logic [6:0]   o_hex7_n
);
    localparam logic [31:0] LAST = BLINK_DIV - 32'd1;
    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [31:0] r_data;
    logic [31:0] r_cnt;
    logic [7:0]  r_blank;
    logic [7:0]  r_blink;
    logic        r_phase;
    logic [6:0]  r_hex [8];
    logic [6:0]  w_hex [8];
    logic        w_wr_data;
    logic        w_wr_ctrl;
    logic        w_wrap;
    assign w_wr_data = bus.en & bus.wr & ~bus.addr;
    assign w_wr_ctrl = bus.en & bus.wr & bus.addr;
    assign w_wrap    = r_cnt == LAST;
    assign bus.dout  = bus.addr ? {r_phase, 15'b0, r_blink, r_blank} : r_data;
    for (genvar k = 0; k < 8; k++) begin : g_dig
        assign w_hex[k] = (r_blank[k] | (r_blink[k] & r_phase)) ? 7'h7F : ~SEG[r_data[4*k +: 4]];
    end
    // a CTRL write restarts the timer so blinking digits begin visible
    always_ff @(posedge clk)
        if (rst) begin
            r_data  <= '0;
            r_blank <= '0;
            r_blink <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_hex   <= '{default: 7'h7F};
        end else begin
            if (w_wr_data) r_data <= bus.din;
            if (w_wr_ctrl) begin
                r_blank <= bus.din[7:0];
                r_blink <= bus.din[15:8];
            end
            r_cnt   <= (w_wr_ctrl || w_wrap) ? '0 : r_cnt + 32'd1;
            r_phase <= w_wr_ctrl ? 1'b0 : r_phase ^ w_wrap;
            r_hex   <= w_hex;
        end
    assign o_hex0_n = r_hex[0];
    assign o_hex1_n = r_hex[1];
    assign o_hex2_n = r_hex[2];
    assign o_hex3_n = r_hex[3];
    assign o_hex4_n = r_hex[4];
    assign o_hex5_n = r_hex[5];
    assign o_hex6_n = r_hex[6];
    assign o_hex7_n = r_hex[7];
endmodule

// File: tb/tb_hex_display.sv
// tb_hex_display: scoreboard bench for hex_display with BLINK_DIV=4 and BLINK_DIV=1 instances
module tb_hex_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   nid = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hex_display_if bus_a ();
    hex_display_if bus_b ();
    logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [6:0] b0, b1, b2, b3, b4, b5, b6, b7;
    wire [55:0] hex_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    wire [55:0] hex_b = {b7, b6, b5, b4, b3, b2, b1, b0};

    hex_display #(.BLINK_DIV(32'd4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .o_hex0_n(a0), .o_hex1_n(a1), .o_hex2_n(a2), .o_hex3_n(a3),
        .o_hex4_n(a4), .o_hex5_n(a5), .o_hex6_n(a6), .o_hex7_n(a7)
    );
    hex_display #(.BLINK_DIV(32'd1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .o_hex0_n(b0), .o_hex1_n(b1), .o_hex2_n(b2), .o_hex3_n(b3),
        .o_hex4_n(b4), .o_hex5_n(b5), .o_hex6_n(b6), .o_hex7_n(b7)
    );

    typedef struct {
        int          due;
        bit          dut;
        bit          kind;
        logic [55:0] exp;
        int          id;
    } item_t;
    item_t q[$];
    item_t it;
    logic [55:0] act;

    localparam logic [55:0] DARK = {8{7'h7F}};
    localparam logic [55:0] ZERO = {8{7'h40}};
    localparam logic [55:0] VIS8 = {{4{7'h00}}, {4{7'h7F}}};

    // monitor: compare every expectation due by this cycle at the falling edge
    always @(negedge clk)
        while (q.size() > 0 && q[0].due <= cyc) begin
            it  = q.pop_front();
            act = it.dut ? (it.kind ? {24'b0, bus_b.dout} : hex_b)
                         : (it.kind ? {24'b0, bus_a.dout} : hex_a);
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s#%0d dut=%0d got=%h want=%h", it.kind ? "dout" : "hex", it.id, it.dut, act, it.exp);
            end
        end

    task automatic push(input bit d, input bit k, input logic [55:0] e);
        q.push_back('{cyc, d, k, e, nid});
        nid++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input bit d, input bit e, input bit w, input bit a, input logic [31:0] v);
        if (d) begin
            bus_b.en = e; bus_b.wr = w; bus_b.addr = a; bus_b.din = v;
        end else begin
            bus_a.en = e; bus_a.wr = w; bus_a.addr = a; bus_a.din = v;
        end
    endtask

    task automatic ctrl_blink(input int n);
        bus_set(0, 1, 1, 1, 32'h0000F00F);
        tick();
        bus_set(0, 0, 0, 1, 32'h0);
        for (int i = 1; i <= n; i++) begin
            tick();
            push(0, 1, {24'b0, ((i / 4) % 2 == 1), 15'b0, 16'hF00F});
            push(0, 0, ((i - 1) / 4) % 2 == 1 ? DARK : VIS8);
        end
    endtask

    initial begin
        bus_set(0, 1, 1, 0, 32'hFFFFFFFF);
        bus_set(1, 0, 0, 0, 32'h0);
        tick();
        tick();
        push(0, 1, 56'h0);
        push(0, 0, DARK);
        bus_set(0, 1, 1, 1, 32'hFFFFFFFF);
        tick();
        push(0, 1, 56'h0);
        rst = 1'b0;
        bus_set(0, 0, 0, 0, 32'h0);
        push(0, 0, DARK);
        push(0, 1, 56'h0);
        tick();
        push(0, 0, ZERO);

        bus_set(0, 1, 1, 0, 32'h0123ABCF);
        tick();
        bus_set(0, 0, 0, 0, 32'h0);
        push(0, 0, ZERO);
        tick();
        push(0, 0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E});
        push(0, 1, {24'b0, 32'h0123ABCF});

        bus_set(0, 1, 1, 0, 32'h88888888);
        tick();
        ctrl_blink(11);
        ctrl_blink(7);
        ctrl_blink(4);

        bus_set(0, 1, 1, 1, 32'hFFFF0303);
        tick();
        bus_set(0, 0, 0, 1, 32'h0);
        push(0, 1, 56'h00000303);
        tick();
        push(0, 1, 56'h00000303);
        push(0, 0, {{6{7'h00}}, 7'h7F, 7'h7F});

        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_set(0, 0, 0, 0, 32'h0);
        push(0, 0, DARK);
        push(0, 1, 56'h0);
        tick();
        bus_set(0, 0, 0, 1, 32'h0);
        push(0, 0, ZERO);
        push(0, 1, 56'h0);

        bus_set(1, 1, 1, 0, 32'h00000005);
        tick();
        bus_set(1, 1, 1, 1, 32'h00000100);
        tick();
        bus_set(1, 0, 0, 1, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            push(1, 0, {{7{7'h40}}, (i % 2 == 0) ? 7'h7F : 7'h12});
            push(1, 1, {24'b0, (i % 2 == 1), 15'b0, 16'h0100});
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            bad += q.size();
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_display.md
Name: hex_display

Overview:
- Bus-writable driver for the board's eight seven-segment displays (HEX7..HEX0), the output counterpart to the switch/key input path of board I/O.
- The CPU writes a 32-bit value, shown as eight hex digits, plus a control word with per-digit blank and blink masks.
- An internal blink timer gates blinking digits.
- All segment outputs are registered and active-low.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); legal range 1..2^32-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  device selected this cycle.
- wr  in  1  write strobe, qualified by en.
- addr  in  1  register select: 0 = DATA, 1 = CTRL.
- din  in  32  write data.
- dout  out  32  read data, combinational from the addressed register.
- hex7_n..hex0_n  out  7 each  segment drives, active-low. Bit 0 = seg a … bit 6 = seg g. hexK shows DATA[4K+3:4K].

Behaviour:
- Reset, sampled at posedge clk when rst=1:
  - DATA=0, CTRL=0, blink counter=0, phase=0.
  - All hexK_n = 7'h7F (dark).
  - rst has priority over any write in the same cycle.
- Register writes:
  - A write occurs at posedge clk when en & wr & ~rst.
  - addr=0: DATA <= din.
  - addr=1: blank <= din[7:0], blink <= din[15:8]. Other din bits are ignored. Counter and phase are also cleared, so blinking digits restart in the visible phase.
- Reads, combinational, independent of en/wr:
  - addr=0: dout = DATA.
  - addr=1: dout = {phase, 15'b0, blink[7:0], blank[7:0]}.
- Blink timer:
  - Counter increments each cycle.
  - When it equals BLINK_DIV-1, it wraps to 0 and phase toggles.
  - BLINK_DIV=1: phase toggles every cycle.
  - The counter is 32 bits and runs even when the blink mask is 0.
- Digit visibility: digit K is dark iff blank[K] | (blink[K] & phase). blank takes precedence.
- Segment encoding, active-high before inversion, digit value → pattern:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Output is the bitwise inverse of the pattern; a dark digit outputs 7'h7F.
- Output latency:
  - hexK_n is a register computed from the current DATA, CTRL and phase.
  - A write at edge N appears on the outputs after edge N+1.
  - A phase toggle at edge N appears after edge N+1.
- Write and blink wrap in the same cycle: a CTRL write wins, so counter=0 and phase=0. A DATA write does not disturb the timer.
- Reset mid-blink or mid-display: all state returns to reset values in one cycle. The next cycle shows dark displays.

Test Plan:
- Reset then idle → all hexK_n=7F, dout=0 for both addr values. Hold rst with en=wr=1, din=FFFFFFFF → registers remain 0.
- Write DATA=0x0123ABCF, CTRL=0 → after 2 edges:
  - hex0_n=~71=0E, hex1_n=~39=46, hex2_n=~7C=03, hex3_n=~77=08
  - hex4_n=~4F=30, hex5_n=~5B=24, hex6_n=~06=79, hex7_n=~3F=40
  - read addr0 = 0x0123ABCF.
- With BLINK_DIV=4, DATA=0x88888888, CTRL=0x0000F00F:
  - digits 0..3 blank (7F) at all times.
  - digits 4..7 alternate 00 / 7F every 4 cycles.
  - read addr1 bit31 tracks phase.
- With BLINK_DIV=4, issue a CTRL write in the cycle where counter=3 and phase=1 → phase reads 0 next cycle, and the next toggle occurs exactly 4 cycles later.
- With BLINK_DIV=1, blink=0x01 → hex0_n toggles every cycle between the digit pattern and 7F.
- Write CTRL din=0xFFFF0303 → read addr1 returns {phase,15'b0,8'h03,8'h03}; the upper din bits are discarded.
